// File: rtl/mem_access_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port of mem_access_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_access_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [1:0]  p0_size;
    logic        p0_unsigned;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_ack;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p0_err;

    logic        p1_req;
    logic        p1_we;
    logic [1:0]  p1_size;
    logic        p1_unsigned;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_ack;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        p1_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read_en;
    logic        mem_wb_en;
    logic        mem_wh_en;
    logic        mem_ww_en;
    logic [31:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_size, p0_unsigned, p0_addr, p0_wdata,
        output p0_ack, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_size, p1_unsigned, p1_addr, p1_wdata,
        output p1_ack, p1_rvalid, p1_rdata, p1_err,
        output mem_addr, mem_wdata, mem_read_en, mem_wb_en, mem_wh_en, mem_ww_en,
        input  mem_rdata
    );

    modport master (
        output p0_req, p0_we, p0_size, p0_unsigned, p0_addr, p0_wdata,
        input  p0_ack, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_size, p1_unsigned, p1_addr, p1_wdata,
        input  p1_ack, p1_rvalid, p1_rdata, p1_err,
        input  mem_addr, mem_wdata, mem_read_en, mem_wb_en, mem_wh_en, mem_ww_en,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Two-port arbiter in front of the byte-addressed data memory: one access every two cycles,
// with alignment/range rejection and sign/zero extension of load data.
module mem_access_arbiter #(
    parameter int unsigned MEM_BYTES = 8192,
    parameter bit          PRIO_MODE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_access_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, ACCESS} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    logic        grant;
    logic [2:0]  nbytes;
    logic [32:0] last_byte;
    logic        misaligned;
    logic        reject;
    logic [31:0] ext_rdata;
    logic [1:0]  ack;
    logic        err;
    logic        rd_en, wb_en, wh_en, ww_en;

    // Round-robin gives a tie to the port that was not served last.
    always_comb begin
        if (bus.p0_req && bus.p1_req) grant = PRIO_MODE ? 1'b0 : ~last_grant_q;
        else                          grant = bus.p1_req;
    end

    // The range check uses a 33-bit sum so an address near 2^32 cannot wrap into range.
    always_comb begin
        case (size_q)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        last_byte  = {1'b0, addr_q} + 33'(nbytes) - 33'd1;
        misaligned = (size_q == 2'b01 && addr_q[0]) || (size_q == 2'b10 && addr_q[1:0] != 2'b00);
        reject     = (size_q == 2'b11) || misaligned || (last_byte >= 33'(MEM_BYTES));
    end

    always_comb begin
        case (size_q)
            2'b00:   ext_rdata = {{24{~uns_q & bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
            2'b01:   ext_rdata = {{16{~uns_q & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
            default: ext_rdata = bus.mem_rdata;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rvalid_d     = 2'b00;
        rdata_d      = 32'd0;
        ack          = 2'b00;
        err          = 1'b0;
        rd_en        = 1'b0;
        wb_en        = 1'b0;
        wh_en        = 1'b0;
        ww_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.p0_req || bus.p1_req) begin
                    port_d  = grant;
                    we_d    = grant ? bus.p1_we       : bus.p0_we;
                    size_d  = grant ? bus.p1_size     : bus.p0_size;
                    uns_d   = grant ? bus.p1_unsigned : bus.p0_unsigned;
                    addr_d  = grant ? bus.p1_addr     : bus.p0_addr;
                    wdata_d = grant ? bus.p1_wdata    : bus.p0_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ack[port_q]  = 1'b1;
                err          = reject;
                rd_en        = ~we_q & ~reject;
                wb_en        = we_q & ~reject & (size_q == 2'b00);
                wh_en        = we_q & ~reject & (size_q == 2'b01);
                ww_en        = we_q & ~reject & (size_q == 2'b10);
                last_grant_d = port_q;
                if (!we_q) begin
                    rvalid_d[port_q] = 1'b1;
                    rdata_d          = reject ? 32'd0 : ext_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rvalid_q     <= 2'b00;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.p0_ack      = ack[0];
    assign bus.p1_ack      = ack[1];
    assign bus.p0_err      = ack[0] & err;
    assign bus.p1_err      = ack[1] & err;
    assign bus.p0_rvalid   = rvalid_q[0];
    assign bus.p1_rvalid   = rvalid_q[1];
    assign bus.p0_rdata    = rvalid_q[0] ? rdata_q : 32'd0;
    assign bus.p1_rdata    = rvalid_q[1] ? rdata_q : 32'd0;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_read_en = rd_en;
    assign bus.mem_wb_en   = wb_en;
    assign bus.mem_wh_en   = wh_en;
    assign bus.mem_ww_en   = ww_en;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: a round-robin instance on a byte-array memory model
// and a fixed-priority instance used for the starvation pattern.
`timescale 1ns/1ps
module tb_mem_access_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_arbiter_if bus ();
    mem_access_arbiter_if bus_fp ();

    mem_access_arbiter #(.MEM_BYTES(8192), .PRIO_MODE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    mem_access_arbiter #(.MEM_BYTES(8192), .PRIO_MODE(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(bus_fp.slave));

    // Byte-array memory: combinational little-endian read, write on the rising edge.
    logic [7:0] mem [0:8191] = '{default: 8'h00};

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return (a < 32'd8192) ? mem[a[12:0]] : 8'h00;
    endfunction

    assign bus.mem_rdata = {rd_byte(bus.mem_addr + 32'd3), rd_byte(bus.mem_addr + 32'd2),
                            rd_byte(bus.mem_addr + 32'd1), rd_byte(bus.mem_addr)};
    assign bus_fp.mem_rdata = 32'h0;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if ((bus.mem_ww_en || (i == 0 && (bus.mem_wb_en || bus.mem_wh_en)) || (i == 1 && bus.mem_wh_en))
                && (bus.mem_addr + 32'(i)) < 32'd8192)
                mem[13'(bus.mem_addr + 32'(i))] <= bus.mem_wdata[8*i +: 8];
        end
    end

    int checks = 0;
    int errors = 0;

    int          o_lat;
    logic        o_err;
    logic [3:0]  o_en;
    logic        o_other;
    logic        o_rvalid;
    logic [31:0] o_rdata;

    task automatic drive_req(input bit port, input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (!port) begin
            bus.p0_we = we; bus.p0_size = size; bus.p0_unsigned = uns;
            bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_req = 1'b1;
        end else begin
            bus.p1_we = we; bus.p1_size = size; bus.p1_unsigned = uns;
            bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_req = 1'b1;
        end
    endtask

    task automatic drop_req(input bit port);
        if (!port) bus.p0_req = 1'b0;
        else       bus.p1_req = 1'b0;
    endtask

    // Runs one access and records what the DUT did; callers compare against their own expectations.
    task automatic access(input bit port, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        drive_req(port, we, size, uns, addr, wdata);
        o_lat = 0; o_err = 1'b0; o_en = 4'b0; o_other = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (port ? bus.p1_ack : bus.p0_ack) begin
                o_lat   = c;
                o_err   = port ? bus.p1_err : bus.p0_err;
                o_en    = {bus.mem_read_en, bus.mem_wb_en, bus.mem_wh_en, bus.mem_ww_en};
                o_other = port ? (bus.p0_ack | bus.p0_err | bus.p0_rvalid) : (bus.p1_ack | bus.p1_err | bus.p1_rvalid);
                break;
            end
        end
        if (o_lat == 0) begin
            checks++; errors++;
            $display("FAIL ack_timeout port=%0d addr=%h got no ack within 8 cycles", port, addr);
        end
        @(posedge clk); #1;
        drop_req(port);
        @(negedge clk);
        o_rvalid = port ? bus.p1_rvalid : bus.p0_rvalid;
        o_rdata  = port ? bus.p1_rdata  : bus.p0_rdata;
    endtask

    task automatic apply_reset;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk); @(negedge clk);
        checks++; if ({bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err, bus.p0_rvalid, bus.p1_rvalid} !== 6'b0) begin
            errors++; $display("FAIL reset_handshake got %b want 000000",
                {bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err, bus.p0_rvalid, bus.p1_rvalid}); end
        checks++; if ({bus.mem_read_en, bus.mem_wb_en, bus.mem_wh_en, bus.mem_ww_en} !== 4'b0) begin
            errors++; $display("FAIL reset_mem_en got %b want 0000",
                {bus.mem_read_en, bus.mem_wb_en, bus.mem_wh_en, bus.mem_ww_en}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.p0_rdata, bus.p1_rdata} !== 128'h0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h want all 0",
                bus.mem_addr, bus.mem_wdata, bus.p0_rdata, bus.p1_rdata); end
        rst_n = 1'b1;
    endtask

    task automatic test_word_store_load;
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL st_latency got %0d want 2", o_lat); end
        checks++; if ({o_err, o_en, o_other} !== 6'b0_0001_0) begin
            errors++; $display("FAIL st_flags err/en/other got %b want 0_0001_0", {o_err, o_en, o_other}); end
        checks++; if ({mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]} !== 32'hDEADBEEF) begin
            errors++; $display("FAIL st_mem got %h want deadbeef", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}); end
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL ld_latency got %0d want 2", o_lat); end
        checks++; if ({o_err, o_en, o_other} !== 6'b0_1000_0) begin
            errors++; $display("FAIL ld_flags err/en/other got %b want 0_1000_0", {o_err, o_en, o_other}); end
        checks++; if ({o_rvalid, o_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL ld_word rvalid/rdata got %b/%h want 1/deadbeef", o_rvalid, o_rdata); end
        // The load goes through port 1 as well, checking the response routing.
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++; if ({o_other, o_rvalid, o_rdata} !== {1'b0, 1'b1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL p1_ld other/rvalid/rdata got %b/%b/%h want 0/1/deadbeef", o_other, o_rvalid, o_rdata); end
    endtask

    task automatic test_extension;
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        checks++; if (o_rdata !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_signed got %h want ffffffde", o_rdata); end
        access(1'b0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        checks++; if (o_rdata !== 32'h000000DE) begin errors++; $display("FAIL lb_unsigned got %h want 000000de", o_rdata); end
        access(1'b0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        checks++; if (o_rdata !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh_signed got %h want ffffdead", o_rdata); end
        access(1'b0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        checks++; if (o_rdata !== 32'h0000DEAD) begin errors++; $display("FAIL lh_unsigned got %h want 0000dead", o_rdata); end
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        checks++; if (o_rdata !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb_signed_lo got %h want ffffffef", o_rdata); end
    endtask

    task automatic test_errors;
        logic [31:0] snap;
        snap = {mem[16'h09], mem[16'h08], mem[16'h07], mem[16'h06]};
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678);
        checks++; if ({o_lat, o_err, o_en} !== {32'd2, 1'b1, 4'b0}) begin
            errors++; $display("FAIL err_misal_word lat/err/en got %0d/%b/%b want 2/1/0000", o_lat, o_err, o_en); end
        checks++; if ({mem[16'h09], mem[16'h08], mem[16'h07], mem[16'h06]} !== snap) begin
            errors++; $display("FAIL err_misal_mem got %h want %h", {mem[16'h09], mem[16'h08], mem[16'h07], mem[16'h06]}, snap); end
        access(1'b0, 1'b0, 2'b01, 1'b0, 32'h01, 32'h0);
        checks++; if ({o_err, o_en, o_rvalid, o_rdata} !== {1'b1, 4'b0, 1'b1, 32'h0}) begin
            errors++; $display("FAIL err_misal_half err/en/rvalid/rdata got %b/%b/%b/%h want 1/0000/1/0", o_err, o_en, o_rvalid, o_rdata); end
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'd8192, 32'h0);
        checks++; if ({o_err, o_en, o_rvalid, o_rdata} !== {1'b1, 4'b0, 1'b1, 32'h0}) begin
            errors++; $display("FAIL err_range_byte err/en/rvalid/rdata got %b/%b/%b/%h want 1/0000/1/0", o_err, o_en, o_rvalid, o_rdata); end
        access(1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        checks++; if ({o_err, o_en, o_rvalid, o_rdata} !== {1'b1, 4'b0, 1'b1, 32'h0}) begin
            errors++; $display("FAIL err_size11 err/en/rvalid/rdata got %b/%b/%b/%h want 1/0000/1/0", o_err, o_en, o_rvalid, o_rdata); end
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0);
        checks++; if ({o_err, o_en} !== {1'b1, 4'b0}) begin
            errors++; $display("FAIL err_range_wrap err/en got %b/%b want 1/0000", o_err, o_en); end
    endtask

    task automatic test_boundary;
        logic [31:0] snap;
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h1FFF, 32'hAAAAAA55);
        checks++; if ({o_err, o_en, mem[16'h1FFF]} !== {1'b0, 4'b0100, 8'h55}) begin
            errors++; $display("FAIL last_byte_store err/en/mem got %b/%b/%h want 0/0100/55", o_err, o_en, mem[16'h1FFF]); end
        access(1'b0, 1'b0, 2'b00, 1'b1, 32'h1FFF, 32'h0);
        checks++; if ({o_err, o_rdata} !== {1'b0, 32'h55}) begin
            errors++; $display("FAIL last_byte_load err/rdata got %b/%h want 0/00000055", o_err, o_rdata); end
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h1FFE, 32'h0000A1B2);
        checks++; if ({o_err, o_en, mem[16'h1FFF], mem[16'h1FFE]} !== {1'b0, 4'b0010, 16'hA1B2}) begin
            errors++; $display("FAIL last_half_store err/en/mem got %b/%b/%h want 0/0010/a1b2", o_err, o_en, {mem[16'h1FFF], mem[16'h1FFE]}); end
        snap = {mem[16'h1FFF], mem[16'h1FFE], mem[16'h1FFD], mem[16'h1FFC]};
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h1FFD, 32'h11223344);
        checks++; if ({o_err, o_en} !== {1'b1, 4'b0}) begin
            errors++; $display("FAIL word_over_end err/en got %b/%b want 1/0000", o_err, o_en); end
        checks++; if ({mem[16'h1FFF], mem[16'h1FFE], mem[16'h1FFD], mem[16'h1FFC]} !== snap) begin
            errors++; $display("FAIL word_over_end_mem got %h want %h",
                {mem[16'h1FFF], mem[16'h1FFE], mem[16'h1FFD], mem[16'h1FFC]}, snap); end
    endtask

    task automatic test_async_reset;
        logic [31:0] snap;
        snap = {mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]};
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
        @(negedge clk);
        @(negedge clk);
        checks++; if ({bus.p0_ack, bus.mem_ww_en} !== 2'b11) begin
            errors++; $display("FAIL rst_pre ack/ww_en got %b want 11", {bus.p0_ack, bus.mem_ww_en}); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({bus.p0_ack, bus.mem_ww_en} !== 2'b00) begin
            errors++; $display("FAIL rst_drop ack/ww_en got %b want 00", {bus.p0_ack, bus.mem_ww_en}); end
        drop_req(1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        checks++; if ({mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]} !== snap) begin
            errors++; $display("FAIL rst_mem got %h want %h", {mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]}, snap); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if ({bus.p0_ack, bus.p1_ack, bus.mem_read_en, bus.mem_wb_en, bus.mem_wh_en, bus.mem_ww_en} !== 6'b0) begin
                errors++; $display("FAIL rst_idle cycle %0d got %b want 000000", c,
                    {bus.p0_ack, bus.p1_ack, bus.mem_read_en, bus.mem_wb_en, bus.mem_wh_en, bus.mem_ww_en}); end
        end
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++; if ({o_lat, o_rdata} !== {32'd2, 32'hDEADBEEF}) begin
            errors++; $display("FAIL rst_after_access lat/rdata got %0d/%h want 2/deadbeef", o_lat, o_rdata); end
    endtask

    task automatic test_round_robin;
        logic [1:0] got, exp, got_fp, exp_fp;
        apply_reset();
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        bus_fp.p0_req = 1'b1;
        bus_fp.p1_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            got    = {bus.p1_ack, bus.p0_ack};
            exp    = (c % 2 == 1) ? 2'b00 : ((c % 4 == 2) ? 2'b01 : 2'b10);
            got_fp = {bus_fp.p1_ack, bus_fp.p0_ack};
            exp_fp = (c % 2 == 1) ? 2'b00 : 2'b01;
            checks++; if (got !== exp) begin
                errors++; $display("FAIL rr_ack cycle %0d {p1,p0} got %b want %b", c, got, exp); end
            checks++; if (got_fp !== exp_fp) begin
                errors++; $display("FAIL fp_ack cycle %0d {p1,p0} got %b want %b", c, got_fp, exp_fp); end
        end
        @(posedge clk); #1;
        drop_req(1'b0);
        drop_req(1'b1);
        bus_fp.p0_req = 1'b0;
        bus_fp.p1_req = 1'b0;
        @(negedge clk);
        checks++; if ({bus.p0_rvalid, bus.p1_rvalid, bus.p1_rdata} !== {1'b0, 1'b1, 32'h0}) begin
            errors++; $display("FAIL rr_last_rvalid p0v/p1v/p1rdata got %b/%b/%h want 0/1/00000000",
                bus.p0_rvalid, bus.p1_rvalid, bus.p1_rdata); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        {bus.p0_req, bus.p0_we, bus.p0_size, bus.p0_unsigned, bus.p0_addr, bus.p0_wdata} = '0;
        {bus.p1_req, bus.p1_we, bus.p1_size, bus.p1_unsigned, bus.p1_addr, bus.p1_wdata} = '0;
        {bus_fp.p0_req, bus_fp.p0_we, bus_fp.p0_size, bus_fp.p0_unsigned, bus_fp.p0_addr, bus_fp.p0_wdata} = '0;
        {bus_fp.p1_req, bus_fp.p1_we, bus_fp.p1_size, bus_fp.p1_unsigned, bus_fp.p1_addr, bus_fp.p1_wdata} = '0;
        test_reset();
        test_word_store_load();
        test_extension();
        test_errors();
        test_boundary();
        test_async_reset();
        test_round_robin();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
